// File: rtl/alu_pipe_hs_if.sv
// Operand/result handshake bundle for alu_pipe_hs.
// master: operand-issue / writeback side; slave: the ALU itself.
interface alu_pipe_hs_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       alu_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, alu_sel, out_ready,
    input  in_ready, out_valid, alu_out, carry_out, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, alu_sel, out_ready,
    output in_ready, out_valid, alu_out, carry_out, overflow, zero, negative
  );
endinterface

// File: rtl/alu_pipe_hs.sv
// Sequential ALU with registered result/flags, valid/ready on both sides and
// an iterative shift-add multiply. One operation in flight at a time.
module alu_pipe_hs #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_pipe_hs_if.slave bus
);
  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned CNT_W = SHW + 1;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSll = 3'b101;
  localparam logic [2:0] OpSra = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic               ovf_q;
  logic               zero_q;
  logic               neg_q;
  logic               valid_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   res_c;
  logic               carry_c;
  logic               ovf_c;
  logic [2*WIDTH-1:0] acc_nxt;

  // Single-cycle result and flags for every opcode except MUL.
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} - {1'b0, bus.b};
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    case (bus.alu_sel)
      OpAdd: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        res_c   = diff[WIDTH-1:0];
        carry_c = diff[WIDTH];  // borrow: a < b unsigned
        ovf_c   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpAnd:   res_c = bus.a & bus.b;
      OpOr:    res_c = bus.a | bus.b;
      OpXor:   res_c = bus.a ^ bus.b;
      OpSll:   res_c = bus.a << bus.b[SHW-1:0];
      OpSra:   res_c = $unsigned($signed(bus.a) >>> bus.b[SHW-1:0]);
      default: res_c = '0;  // MUL goes through the iterative path
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      res_q    <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            if (bus.alu_sel == OpMul) begin
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, bus.a};
              mplier_q <= bus.b;
              cnt_q    <= CNT_W'(WIDTH);
              state_q  <= StMul;
            end else begin
              res_q   <= res_c;
              carry_q <= carry_c;
              ovf_q   <= ovf_c;
              zero_q  <= (res_c == '0);
              neg_q   <= res_c[WIDTH-1];
              valid_q <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CNT_W'(1);
          // Last iteration: commit the product taken straight from this step's sum.
          if (cnt_q == CNT_W'(1)) begin
            res_q   <= acc_nxt[WIDTH-1:0];
            carry_q <= |acc_nxt[2*WIDTH-1:WIDTH];
            ovf_q   <= 1'b0;
            zero_q  <= (acc_nxt[WIDTH-1:0] == '0);
            neg_q   <= acc_nxt[WIDTH-1];
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = valid_q;
  assign bus.alu_out   = res_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
endmodule

// File: tb/tb_alu_pipe_hs.sv
// Self-checking bench for alu_pipe_hs: directed cases plus random ops against
// an arithmetic reference model.
module tb_alu_pipe_hs;
  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [W-1:0] last_res;
  logic         last_c;
  logic         last_v;
  logic         last_z;
  logic         last_n;

  alu_pipe_hs_if #(.WIDTH(W)) bus ();

  alu_pipe_hs #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's definition.
  function automatic void model(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic c, output logic v);
    longint      sa;
    longint      sb;
    longint      sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    case (sel)
      3'd0: begin
        p  = {32'b0, a} + {32'b0, b};
        r  = p[31:0];
        c  = (p > 64'hFFFF_FFFF);
        sr = sa + sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        c  = (a < b);
        sr = sa - sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = $unsigned($signed(a) >>> b[4:0]);
      default: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0];
        c = (p > 64'hFFFF_FFFF);
      end
    endcase
  endfunction

  // Issue one op from IDLE, check latency/result, optionally stall the output, then drain.
  task automatic run_op(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall);
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    int           lat;
    int           rdy_bad;
    model(sel, a, b, er, ec, ev);
    check("in_ready_pre", 64'(bus.in_ready), 64'd1);
    bus.a         = a;
    bus.b         = b;
    bus.alu_sel   = sel;
    bus.in_valid  = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    // Operands were captured; scramble them to prove it.
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.alu_sel  = 3'($urandom);
    lat     = 1;
    rdy_bad = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_bad++;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), (sel == 3'd7) ? 64'd33 : 64'd1);
    check("in_ready_busy", 64'(rdy_bad), 64'd0);
    check("in_ready_done", 64'(bus.in_ready), 64'd0);
    check("alu_out", 64'(bus.alu_out), 64'(er));
    check("carry_out", 64'(bus.carry_out), 64'(ec));
    check("overflow", 64'(bus.overflow), 64'(ev));
    check("zero", 64'(bus.zero), 64'(er == 0));
    check("negative", 64'(bus.negative), 64'(er[W-1]));
    last_res = bus.alu_out;
    last_c   = bus.carry_out;
    last_v   = bus.overflow;
    last_z   = bus.zero;
    last_n   = bus.negative;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.alu_sel  = 3'd0;
      bus.a        = 32'd1;
      bus.b        = 32'd1;
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_out", 64'(bus.alu_out), 64'(er));
      check("hold_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_valid", 64'(bus.out_valid), 64'd0);
    check("drain_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int seen;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.alu_sel   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out", 64'(bus.alu_out), 64'd0);
    check("rst_flags", 64'({bus.carry_out, bus.overflow, bus.zero, bus.negative}), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    check("add_wrap", 64'({last_res, last_c, last_z, last_v, last_n}),
          64'({32'h0, 1'b1, 1'b1, 1'b0, 1'b0}));
    run_op(3'd1, 32'h8000_0000, 32'h0000_0001, 0);
    check("sub_ovf", 64'({last_res, last_v, last_c}), 64'({32'h7FFF_FFFF, 1'b1, 1'b0}));
    run_op(3'd1, 32'h0000_0005, 32'h0000_0007, 0);
    check("sub_borrow", 64'({last_res, last_c, last_n}), 64'({32'hFFFF_FFFE, 1'b1, 1'b1}));
    run_op(3'd7, 32'h0000_FFFF, 32'h0001_0001, 0);
    check("mul_low", 64'({last_res, last_c}), 64'({32'hFFFF_FFFF, 1'b0}));
    run_op(3'd7, 32'h0001_0000, 32'h0001_0000, 0);
    check("mul_high", 64'({last_res, last_c, last_z}), 64'({32'h0, 1'b1, 1'b1}));
    run_op(3'd6, 32'h8000_0000, 32'h0000_001F, 0);
    check("sra_fill", 64'(last_res), 64'h0000_0000_FFFF_FFFF);
    run_op(3'd5, 32'h0000_0001, 32'h0000_0024, 0);
    check("sll_amt", 64'(last_res), 64'h10);
    run_op(3'd5, 32'h1234_5678, 32'h0000_0020, 0);
    check("sll_zero_amt", 64'(last_res), 64'h1234_5678);
    run_op(3'd4, 32'h0000_00FF, 32'h0000_000F, 5);
    check("xor_bp", 64'(last_res), 64'hF0);

    // Reset in the middle of a multiply.
    check("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    bus.a         = 32'h0000_1234;
    bus.b         = 32'h0000_5678;
    bus.alu_sel   = 3'd7;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_out", 64'(bus.alu_out), 64'd0);
    check("abort_flags", 64'({bus.carry_out, bus.overflow, bus.zero, bus.negative}), 64'd0);
    check("abort_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("abort_no_output", 64'(seen), 64'd0);
    bus.out_ready = 1'b0;
    run_op(3'd0, 32'd3, 32'd4, 0);
    check("add_after_abort", 64'(last_res), 64'd7);

    // Random ops, with occasional small operands to reach zero/borrow corners.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
